sram_fifo_ctrl: RTL
===================

# sram_fifo_ctrl

Valid/ready FIFO controller that uses the generated 1R1W SRAM wrapper (`mem_1r1w`, 48 x 64) as backing storage. It sits directly upstream of the memory: it drives the write and read ports and turns the macro's one-cycle registered read into a streaming output through a 2-entry output buffer. Total capacity is DEPTH + 2 entries.

## Interface
- DEPTH, 48, memory entries; must equal the wrapper depth; need not be a power of two
- WIDTH, 64, data width; must equal the wrapper width
- ADDR_W, 6, memory address width, clog2(DEPTH)
- clock  in  1  single clock; the parent also ties the memory's R0_clk and W0_clk to it
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream has data
- in_ready  out  1  FIFO can accept
- in_data  in  WIDTH  write payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  head entry
- count  out  clog2(DEPTH+3)  total entries held: memory + in-flight + buffer
- mem_W0_addr  out  ADDR_W  memory write address
- mem_W0_en  out  1  memory write enable
- mem_W0_data  out  WIDTH  memory write data
- mem_R0_addr  out  ADDR_W  memory read address
- mem_R0_en  out  1  memory read enable
- mem_R0_data  in  WIDTH  memory read data; valid in the cycle after mem_R0_en

## Operation
- **Handshakes:** in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- **in_ready:** in_ready = (mem_count < DEPTH). It is combinational from registered state only and does not depend on out_ready.
- **Write path:** on in_fire, mem_W0_en=1, mem_W0_addr=wptr, mem_W0_data=in_data.
  - wptr increments and wraps DEPTH-1 -> 0 by explicit compare, never by bit truncation.
- **Read issue:** issue when mem_count > 0 and (buf_count + inflight - out_fire) < 2.
  - On issue: mem_R0_en=1, mem_R0_addr=rptr, rptr advances with the same wrap rule, inflight is set for one cycle.
- **Read return:** in the cycle after an issue, mem_R0_data is written into the output buffer tail.
- **Counters:**
  - mem_count counts committed memory entries: +1 on in_fire, -1 on read issue, both may happen in the same cycle.
  - A read never targets an address written in the same cycle, because mem_count excludes the current write. No read/write collision handling is needed.
- **Output buffer:** 2-entry FIFO. out_valid = (buf_count > 0); out_data = buffer head.
  - It can never overflow, because issue is gated by the read-issue condition above.
- **count** = mem_count + inflight + buf_count.
- **Reset:** synchronous; clears wptr, rptr, mem_count, inflight and buf_count.
  - After reset: in_ready=1, out_valid=0, count=0, mem_W0_en=0, mem_R0_en=0, out_data=0.
  - Reset asserted mid-transfer discards all contents, including a read in flight. The returning mem_R0_data is ignored.

## Timing
- Latency without flow-through: in_fire in cycle t, write in t, read issue in t+1, capture at end of t+2, out_valid=1 in t+3.
- Sustained throughput: 1 entry per cycle in each direction once the output buffer is primed.
- Full: when mem_count==DEPTH, in_ready=0 in that cycle. A same-cycle read issue lowers mem_count, so in_ready=1 in the next cycle.
- Empty: out_valid=0 whenever buf_count==0. There is no combinational path from in_valid to out_valid.
- Simultaneous in_fire, issue and out_fire: all counters update consistently and count is unchanged.

## Configuration
- `SRAM_FIFO_FLOW_EN` defined:
  - Flow-through applies when mem_count==0, inflight==0, and either buf_count==0 or buf_count==1 with out_fire.
  - Under that condition, in_fire writes in_data directly into the output buffer. It does not write the memory and mem_W0_en stays 0.
  - out_valid rises in t+1.
  - Ordering is preserved, because flow-through only happens when nothing is older in the memory or in flight.
- Not defined: every entry passes through the memory, with latency 3.

## Structure
- Package `sram_fifo_pkg` holds DEPTH, WIDTH, ADDR_W, the count width localparam and the pointer-wrap function `ptr_inc`.
- Sub-module `sram_fifo_obuf`: the 2-entry output buffer, with push, pop, data, count and registered head. It is instantiated once.

## Test plan
- Reset, then push 0x1..0x3 back-to-back with out_ready=1:
  - without the macro, out_data = 0x1, 0x2, 0x3 in cycles 3, 4, 5 after the first push;
  - with `SRAM_FIFO_FLOW_EN`, in cycles 1, 2, 3.
- Fill with out_ready=0:
  - in_ready drops after 50 accepted entries (48 memory + 2 buffer), and count=50;
  - drain 50 entries and check in-order data and count=0.
- Wrap-around: stream 200 entries with random out_ready stalls.
  - Data is in order, and mem_W0_addr and mem_R0_addr never exceed 47 and wrap 47 -> 0.
- Full boundary: with mem_count=48, pulse out_ready for one cycle and hold in_valid.
  - Exactly one new entry is accepted on the following cycle.
- Reset mid-stream: assert reset in the cycle after a read issue.
  - out_valid=0, count=0 and in_ready=1 on the next cycle, and the stale mem_R0_data is never output.
- Simultaneous push/pop at steady state, count=5: one push and one pop per cycle for 20 cycles.
  - count stays 5 and there are no mem_R0_addr == mem_W0_addr collisions while both enables are high.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared parameters and helpers for the SRAM-backed FIFO controller.
//   DEPTH  : entries in the 1R1W memory macro (not necessarily a power of two)
//   WIDTH  : payload width, equal to the macro width
//   ADDR_W : memory address width
//   CNT_W  : width of the total occupancy count (memory + in-flight + buffer)
//   ptr_inc: pointer advance with explicit wrap at DEPTH-1
package sram_fifo_pkg;

  localparam int unsigned DEPTH  = 48;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 3);

  // DEPTH is not a power of two, so the wrap is an explicit compare.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
    if (ptr == ADDR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + 1'b1;
    end
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Streaming interface of the SRAM FIFO controller.
//   in_valid/in_ready/in_data    : upstream valid/ready write channel
//   out_valid/out_ready/out_data : downstream valid/ready read channel
//   count                        : total entries held by the FIFO
// Modports: master = environment driving the FIFO, slave = the FIFO itself.
interface sram_fifo_ctrl_if;
  import sram_fifo_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer that turns the memory's registered read into a stream.
// The head entry is held in a register so out_data never depends on the memory.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : tail write data
//   pop_i         : remove the head entry
//   head_o        : head entry (registered)
//   count_o       : entries held, 0..2
// The controller never pushes into a full buffer unless it pops in the same cycle.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push_i) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push_i, pop_i})
          2'b10: begin
            tail_d  = push_data_i;
            count_d = 2'd2;
          end
          2'b01: count_d = 2'd0;
          // Pop and push together: new entry becomes the head directly.
          2'b11: head_d = push_data_i;
          default: ;
        endcase
      end
      2'd2: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller backed by a 1R1W SRAM macro (mem_1r1w, DEPTH x WIDTH).
// Writes go straight to the memory; reads are issued ahead into a two-entry output
// buffer so that the one-cycle registered read still streams one entry per cycle.
// Capacity is DEPTH + 2 entries.
//   clk_i          : single clock, also tied to the macro's R0/W0 clocks by the parent
//   rst_i          : synchronous active-high reset; discards all contents
//   bus            : streaming interface (slave side), see sram_fifo_ctrl_if
//   mem_w0_addr_o  : memory write address
//   mem_w0_en_o    : memory write enable
//   mem_w0_data_o  : memory write data
//   mem_r0_addr_o  : memory read address
//   mem_r0_en_o    : memory read enable
//   mem_r0_data_i  : memory read data, valid the cycle after mem_r0_en_o
// Optional feature: define SRAM_FIFO_FLOW_EN to let an input bypass the memory and land
// in the output buffer when nothing older is stored or in flight (latency 1 instead of 3).
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  sram_fifo_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] mem_w0_addr_o,
  output logic              mem_w0_en_o,
  output logic [WIDTH-1:0]  mem_w0_data_o,
  output logic [ADDR_W-1:0] mem_r0_addr_o,
  output logic              mem_r0_en_o,
  input  logic [WIDTH-1:0]  mem_r0_data_i
);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  mem_count_q, mem_count_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        buf_count;
  logic [WIDTH-1:0]  buf_head;
  logic              buf_push;
  logic [WIDTH-1:0]  buf_push_data;

  logic              in_ready;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;
  logic [2:0]        occ;
  logic              room;
  logic              issue;
  logic              flow_ok;
  logic              flow;
  logic              mem_wr;

  // in_ready looks only at registered state, never at out_ready.
  assign in_ready  = (mem_count_q < CNT_W'(DEPTH));
  assign out_valid = (buf_count != 2'd0);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  // Buffer slots already claimed: held entries plus the read returning this cycle.
  assign occ  = {1'b0, buf_count} + {2'b00, inflight_q};
  assign room = (occ < 3'd2) || ((occ == 3'd2) && out_fire);

  // mem_count excludes this cycle's write, so a read never hits the write address.
  assign issue = (mem_count_q != '0) && room;

`ifdef SRAM_FIFO_FLOW_EN
  // Bypass only when nothing older sits in memory or in flight, preserving order.
  assign flow_ok = (mem_count_q == '0) && !inflight_q &&
                   ((buf_count == 2'd0) || ((buf_count == 2'd1) && out_fire));
`else
  assign flow_ok = 1'b0;
`endif

  assign flow   = in_fire & flow_ok;
  assign mem_wr = in_fire & ~flow;

  // Returning read data and bypass data are mutually exclusive (flow needs !inflight).
  assign buf_push      = inflight_q | flow;
  assign buf_push_data = inflight_q ? mem_r0_data_i : bus.in_data;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    inflight_d  = issue;
    mem_count_d = mem_count_q + CNT_W'(mem_wr) - CNT_W'(issue);
    if (mem_wr) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (issue) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
    end
  end

  sram_fifo_obuf u_obuf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (buf_push),
    .push_data_i (buf_push_data),
    .pop_i       (out_fire),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  assign mem_w0_en_o   = mem_wr;
  assign mem_w0_addr_o = wptr_q;
  assign mem_w0_data_o = bus.in_data;
  assign mem_r0_en_o   = issue;
  assign mem_r0_addr_o = rptr_q;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_head;
  assign bus.count     = mem_count_q + CNT_W'(inflight_q) + CNT_W'(buf_count);

endmodule
